// File: rtl/seq_multiplier.sv
// Sequential shift-and-add unsigned multiplier for the calculator datapath.
// Takes one multiplier bit per clock, with a fixed latency of WIDTH cycles
// from the accepting edge to the done pulse.
// Ports:
//   clk    - system clock, rising edge
//   rst_n  - asynchronous active-low reset
//   start  - begin a multiply; accepted in IDLE or DONE
//   A, B   - multiplicand / multiplier, sampled only on the accepting edge
//   busy   - high while the iteration runs
//   done   - one-cycle completion pulse
//   P      - 2*WIDTH-bit product, held until the next completion or reset
//   ovf    - product does not fit in WIDTH bits; held with P
module seq_multiplier #(
  parameter int unsigned WIDTH = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic [WIDTH-1:0]   A,
  input  logic [WIDTH-1:0]   B,
  output logic               busy,
  output logic               done,
  output logic [2*WIDTH-1:0] P,
  output logic               ovf
);

  localparam int unsigned PW = 2 * WIDTH;
  localparam int unsigned CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t          state, state_n;
  logic [PW-1:0]   acc, acc_n;
  logic [PW-1:0]   m, m_n;
  logic [WIDTH-1:0] q, q_n;
  logic [CW-1:0]   cnt, cnt_n;
  logic [PW-1:0]   p_n;
  logic            ovf_n;
  logic [PW-1:0]   sum;

  // Next-state and datapath update
  always_comb begin
    state_n = state;
    acc_n   = acc;
    m_n     = m;
    q_n     = q;
    cnt_n   = cnt;
    p_n     = P;
    ovf_n   = ovf;
    sum     = q[0] ? (acc + m) : acc;

    unique case (state)
      IDLE, DONE: begin
        if (start) begin
          state_n = RUN;
          m_n     = {{WIDTH{1'b0}}, A};
          q_n     = B;
          acc_n   = '0;
          cnt_n   = '0;
        end else if (state == DONE) begin
          state_n = IDLE;
        end
      end
      RUN: begin
        acc_n = sum;
        m_n   = m << 1;
        q_n   = q >> 1;
        cnt_n = cnt + CW'(1);
        // Last multiplier bit: publish the final sum instead of waiting a cycle
        if (cnt == CW'(WIDTH - 1)) begin
          state_n = DONE;
          p_n     = sum;
          ovf_n   = |sum[PW-1:WIDTH];
        end
      end
      default: state_n = IDLE;
    endcase
  end

  // State, datapath and registered output decodes
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      acc   <= '0;
      m     <= '0;
      q     <= '0;
      cnt   <= '0;
      P     <= '0;
      ovf   <= 1'b0;
      busy  <= 1'b0;
      done  <= 1'b0;
    end else begin
      state <= state_n;
      acc   <= acc_n;
      m     <= m_n;
      q     <= q_n;
      cnt   <= cnt_n;
      P     <= p_n;
      ovf   <= ovf_n;
      busy  <= (state_n == RUN);
      done  <= (state_n == DONE);
    end
  end

endmodule

// File: tb/tb_seq_multiplier.sv
// Self-checking bench for seq_multiplier (WIDTH=8): directed cases plus
// random operands, checked against plain-arithmetic products.
module tb_seq_multiplier;

  localparam int unsigned WIDTH = 8;

  logic               clk = 1'b0;
  logic               rst_n;
  logic               start;
  logic [WIDTH-1:0]   A;
  logic [WIDTH-1:0]   B;
  logic               busy;
  logic               done;
  logic [2*WIDTH-1:0] P;
  logic               ovf;

  int vectors     = 0;
  int miscompares = 0;
  logic [15:0] exp_p = 16'd0;

  always #5 clk = ~clk;

  seq_multiplier #(.WIDTH(WIDTH)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .A     (A),
    .B     (B),
    .busy  (busy),
    .done  (done),
    .P     (P),
    .ovf   (ovf)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    if (obs !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic logic [15:0] ref_product(input logic [7:0] a, input logic [7:0] b);
    logic [31:0] full;
    full = 32'(a) * 32'(b);
    return full[15:0];
  endfunction

  // One operation from IDLE; j counts edges after the accepting edge
  task automatic do_op(input logic [7:0] a, input logic [7:0] b, input bit scramble,
                       input int pulse_at, input string tag);
    int busy_cnt;
    int done_cnt;
    int done_at;
    logic [15:0] want;
    want = ref_product(a, b);
    @(negedge clk);
    A = a; B = b; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    busy_cnt = 0; done_cnt = 0; done_at = -1;
    for (int j = 0; j <= int'(WIDTH) + 3; j++) begin
      if (j > 0) @(negedge clk);
      if (j == int'(WIDTH) - 1) check({tag, " P held"}, 32'(P), 32'(exp_p));
      if (busy) busy_cnt++;
      if (done) begin
        done_cnt++;
        if (done_at < 0) done_at = j;
        check({tag, " busy in done"}, 32'(busy), 32'(0));
        check({tag, " P"}, 32'(P), 32'(want));
        check({tag, " ovf"}, 32'(ovf), 32'(want > 16'd255));
      end
      start = 1'b0;
      if (scramble) begin
        A = 8'($urandom);
        B = 8'($urandom);
      end
      if (j == pulse_at) begin
        A = 8'd9; B = 8'd9; start = 1'b1;
      end
    end
    start = 1'b0;
    exp_p = want;
    check({tag, " busy cycles"}, 32'(busy_cnt), 32'(WIDTH));
    check({tag, " done count"}, 32'(done_cnt), 32'(1));
    check({tag, " done latency"}, 32'(done_at), 32'(WIDTH));
  endtask

  initial begin
    int j1;
    int j2;
    int cnt_done;
    int cnt_busy;
    logic [7:0] ra;
    logic [7:0] rb;

    rst_n = 1'b0; start = 1'b0; A = '0; B = '0;
    repeat (3) @(negedge clk);
    check("reset busy", 32'(busy), 32'(0));
    check("reset done", 32'(done), 32'(0));
    check("reset P",    32'(P),    32'(0));
    check("reset ovf",  32'(ovf),  32'(0));
    rst_n = 1'b1;

    do_op(8'd13,  8'd11,  1'b0, -1, "13x11");
    do_op(8'd255, 8'd255, 1'b0, -1, "255x255");
    do_op(8'd16,  8'd16,  1'b0, -1, "16x16");
    do_op(8'd15,  8'd17,  1'b0, -1, "15x17");
    do_op(8'd0,   8'd200, 1'b0, -1, "0x200");
    do_op(8'd200, 8'd0,   1'b0, -1, "200x0");
    do_op(8'd6,   8'd7,   1'b1, 3,  "6x7 start in run");

    // Back-to-back with start held high across DONE
    @(negedge clk);
    A = 8'd3; B = 8'd5; start = 1'b1;
    j1 = -1; j2 = -1;
    for (int j = 1; j <= 40 && j2 < 0; j++) begin
      @(negedge clk);
      if (j1 >= 0 && j == j1 + 1) check("b2b busy after done", 32'(busy), 32'(1));
      if (j1 >= 0 && j == j1 + 4) check("b2b P held", 32'(P), 32'(15));
      if (done) begin
        if (j1 < 0) begin
          j1 = j;
          check("b2b first P", 32'(P), 32'(ref_product(8'd3, 8'd5)));
          A = 8'd4; B = 8'd4;
        end else begin
          j2 = j;
          check("b2b second P", 32'(P), 32'(ref_product(8'd4, 8'd4)));
          start = 1'b0;
        end
      end
    end
    start = 1'b0;
    check("b2b first done latency", 32'(j1), 32'(WIDTH + 1));
    check("b2b gap", 32'(j2 - j1), 32'(WIDTH + 1));
    exp_p = 16'd16;
    repeat (2) @(negedge clk);
    check("b2b idle after", 32'(busy), 32'(0));

    // Reset in the middle of RUN
    @(negedge clk);
    A = 8'd100; B = 8'd100; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    check("pre-abort busy", 32'(busy), 32'(1));
    rst_n = 1'b0;
    #1;
    check("abort busy", 32'(busy), 32'(0));
    check("abort done", 32'(done), 32'(0));
    check("abort P",    32'(P),    32'(0));
    check("abort ovf",  32'(ovf),  32'(0));
    @(negedge clk);
    rst_n = 1'b1;
    exp_p = 16'd0;
    cnt_done = 0; cnt_busy = 0;
    for (int j = 0; j < 20; j++) begin
      @(negedge clk);
      if (done) cnt_done++;
      if (busy) cnt_busy++;
    end
    check("post-abort done", 32'(cnt_done), 32'(0));
    check("post-abort busy", 32'(cnt_busy), 32'(0));

    // Random operands, some with A/B churning during RUN
    for (int i = 0; i < 30; i++) begin
      ra = 8'($urandom);
      rb = 8'($urandom);
      if (i % 5 == 0) ra = 8'($urandom_range(0, 15));
      do_op(ra, rb, 1'($urandom), -1, "rand");
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
